crc_stream_check: RTL and testbench

Byte-serial CRC checker for packetized byte streams. It receives a packet made of payload bytes followed by a CRC trailer, computes the CRC over the payload one byte per cycle, and compares it with the trailer. It is the receive-side counterpart of the `crc` hash/generator used by the bloom-filter hashing path. For the same polynomial and initial value, it produces bit-identical CRCs to `crc`.

---
 rtl/crc_stream_check.sv | 162 ++++++++++++++++
 tb/tb_crc_stream_check.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_check.sv
// Byte-serial CRC checker for packetized byte streams.
// A packet is a payload followed by a CRC trailer. The CRC is computed over
// the payload one byte per cycle and compared against the trailer. The last
// CRC_BYTES bytes seen are held back in a short delay line, so the trailer
// never enters the CRC engine.

package crc_pkg;
  // Seed values shared with the crc hash/generator. Index 0 is the default
  // start value. Narrower CRCs use the low bits.
  localparam logic [31:0] CRC_INITS [4] = '{
    32'hFFFF_FFFF,
    32'h0000_0000,
    32'h1D0F_1D0F,
    32'hA5A5_5A5A
  };
endpackage

module crc_stream_check #(
  parameter int              WIDTH = 13,
  parameter logic [WIDTH-1:0] POLY = 13'h1CF5,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(crc_pkg::CRC_INITS[0]),
  parameter int              LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  input  logic             sop_i,
  input  logic             eop_i,
  output logic             ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_ok_o,
  output logic             res_short_o,
  output logic [WIDTH-1:0] res_crc_o,
  output logic [LEN_W-1:0] res_len_o
);

  localparam int CRC_BYTES = (WIDTH + 7) / 8;
  localparam int LINE_W    = CRC_BYTES * 8;
  localparam int FILL_W    = $clog2(CRC_BYTES + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(CRC_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PKT,
    S_RESULT
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   crc, crc_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic [FILL_W-1:0]  fill, fill_nx;
  logic [LINE_W-1:0]  line, line_nx;

  // Per-beat candidate values, used both to advance the packet and to load
  // the result on the eop beat.
  logic [WIDTH-1:0]   crc_base, crc_upd;
  logic [LEN_W-1:0]   len_base, len_upd;
  logic [FILL_W-1:0]  fill_base, fill_upd;
  logic [LINE_W-1:0]  line_upd;
  logic               full;
  logic               short_pkt;
  logic               take;
  logic               res_load;

  // MSB-first CRC update over one byte: no reflection and no final XOR.
  // NOTE: blocking assignments are correct here. This function is pure
  // combinational evaluation, and each bit step must see the previous one.
  function automatic logic [WIDTH-1:0] crc_byte(input logic [WIDTH-1:0] crc_in,
                                                input logic [7:0]       b);
    logic [WIDTH-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[WIDTH-1] ^ b[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign res_valid_o = (state == S_RESULT);
  assign ready_o     = ~res_valid_o;

  // Next-state and datapath update for the accepted beat.
  always_comb begin
    // NOTE: every variable gets a default before any branch. That is what
    // keeps this block free of inferred latches.
    state_nx = state;
    crc_nx   = crc;
    len_nx   = len;
    fill_nx  = fill;
    line_nx  = line;
    take     = 1'b0;
    res_load = 1'b0;

    // A sop beat starts from a clean packet, which also discards any packet
    // that was still in flight.
    crc_base  = sop_i ? INIT : crc;
    len_base  = sop_i ? '0   : len;
    fill_base = sop_i ? '0   : fill;

    // Once the delay line is full, the oldest byte is known to be payload.
    full      = (fill_base == FILL_FULL);
    crc_upd   = full ? crc_byte(crc_base, line[LINE_W-1 -: 8]) : crc_base;
    len_upd   = (full && (len_base != '1)) ? len_base + LEN_W'(1) : len_base;
    fill_upd  = full ? fill_base : fill_base + FILL_W'(1);
    line_upd  = LINE_W'({line, data_i});
    short_pkt = (fill_upd != FILL_FULL);

    unique case (state)
      S_IDLE:   take = valid_i & sop_i;
      S_PKT:    take = valid_i;
      S_RESULT: if (res_ready_i) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    if (take) begin
      crc_nx   = crc_upd;
      len_nx   = len_upd;
      fill_nx  = fill_upd;
      line_nx  = line_upd;
      state_nx = eop_i ? S_RESULT : S_PKT;
      res_load = eop_i;
    end
  end

  // Control, CRC engine and result registers, with synchronous clear.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (!rst_n_i) begin
      state       <= S_IDLE;
      crc         <= '0;
      len         <= '0;
      fill        <= '0;
      res_ok_o    <= 1'b0;
      res_short_o <= 1'b0;
      res_crc_o   <= '0;
      res_len_o   <= '0;
    end else begin
      state <= state_nx;
      crc   <= crc_nx;
      len   <= len_nx;
      fill  <= fill_nx;
      if (res_load) begin
        res_short_o <= short_pkt;
        res_crc_o   <= short_pkt ? INIT : crc_upd;
        res_ok_o    <= ~short_pkt & (crc_upd == line_upd[WIDTH-1:0]);
        res_len_o   <= len_upd;
      end
    end
  end

  // Trailer delay line.
  always_ff @(posedge clk_i) begin
    // NOTE: the delay line is intentionally left out of reset. The fill
    // count marks which bytes are live, so stale contents are never used.
    line <= line_nx;
  end

endmodule

// File: tb/tb_crc_stream_check.sv
// Directed self-checking bench for crc_stream_check.
// Two instances share one stimulus stream:
//  - u_d8 is a CRC-8 configuration (poly 07, init 0, one trailer byte).
//  - u_dd uses the default parameters (13-bit, two trailer bytes).
// Each test checks only the instance it targets.
module tb_crc_stream_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid, sop, eop, res_ready;

  logic        ready_8, rv_8, ok_8, sh_8;
  logic [7:0]  crc_8;
  logic [15:0] len_8;

  logic        ready_d, rv_d, ok_d, sh_d;
  logic [12:0] crc_d;
  logic [15:0] len_d;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pay[$];
  logic [7:0] trl[$];
  logic       res_before;

  // Default init: crc_pkg::CRC_INITS[0] truncated to 13 bits.
  localparam logic [12:0] INIT_D = 13'h1FFF;

  crc_stream_check #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .LEN_W(16)) u_d8 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .sop_i(sop), .eop_i(eop), .ready_o(ready_8), .res_valid_o(rv_8),
    .res_ready_i(res_ready), .res_ok_o(ok_8), .res_short_o(sh_8),
    .res_crc_o(crc_8), .res_len_o(len_8)
  );

  crc_stream_check u_dd (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .sop_i(sop), .eop_i(eop), .ready_o(ready_d), .res_valid_o(rv_d),
    .res_ready_i(res_ready), .res_ok_o(ok_d), .res_short_o(sh_d),
    .res_crc_o(crc_d), .res_len_o(len_d)
  );

  always #5 clk = ~clk;

  // Reference CRC for the default configuration. It XORs each byte into the
  // top of the register and then shifts it out.
  function automatic logic [12:0] ref13();
    logic [12:0] c;
    c = INIT_D;
    foreach (pay[i]) begin
      c = c ^ {pay[i], 5'b0};
      for (int k = 0; k < 8; k++) c = c[12] ? ((c << 1) ^ 13'h1CF5) : (c << 1);
    end
    return c;
  endfunction

  task automatic idle_cycle();
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    data = d; sop = s; eop = e; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  // Sends pay then trl as one packet. An idle gap follows byte gap_at
  // (a negative value means no gap).
  task automatic send_pkt(input int gap_at);
    int n;
    logic [7:0] b;
    n = pay.size() + trl.size();
    for (int i = 0; i < n; i++) begin
      b = (i < pay.size()) ? pay[i] : trl[i - pay.size()];
      if (i == n - 1) res_before = rv_8 | rv_d;
      send(b, i == 0, i == n - 1);
      if (i == gap_at) idle_cycle();
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic load_check_pkt(input logic [7:0] t);
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    trl = '{t};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = 8'h00; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({rv_8, ready_8, ok_8, sh_8} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_ctrl_8: got %b want 0100", {rv_8, ready_8, ok_8, sh_8});
    end
    n_tests++;
    if ({rv_d, ready_d, ok_d, sh_d} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_ctrl_d: got %b want 0100", {rv_d, ready_d, ok_d, sh_d});
    end
    n_tests++;
    if ({crc_d, len_d} !== 29'd0 || {crc_8, len_8} !== 24'd0) begin
      n_fail++; $display("FAIL reset_data: got crc_d=%h len_d=%0d crc_8=%h len_8=%0d want zeros",
                         crc_d, len_d, crc_8, len_8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_crc8_check();
    load_check_pkt(8'hF4);
    send_pkt(-1);
    n_tests++;
    if (res_before !== 1'b0) begin
      n_fail++; $display("FAIL crc8_early_valid: got %b want 0", res_before);
    end
    n_tests++;
    if ({rv_8, ready_8, ok_8, sh_8} !== 4'b1010) begin
      n_fail++; $display("FAIL crc8_flags: got %b want 1010", {rv_8, ready_8, ok_8, sh_8});
    end
    n_tests++;
    if (crc_8 !== 8'hF4 || len_8 !== 16'd9) begin
      n_fail++; $display("FAIL crc8_value: got crc=%h len=%0d want crc=f4 len=9", crc_8, len_8);
    end
    consume();
  endtask

  task automatic test_corrupt();
    load_check_pkt(8'hF5);
    send_pkt(-1);
    n_tests++;
    if (rv_8 !== 1'b1 || ok_8 !== 1'b0 || crc_8 !== 8'hF4) begin
      n_fail++; $display("FAIL corrupt: got valid=%b ok=%b crc=%h want valid=1 ok=0 crc=f4",
                         rv_8, ok_8, crc_8);
    end
    consume();
  endtask

  task automatic test_equiv();
    logic [12:0] exp_crc;
    pay = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    exp_crc = ref13();
    trl = '{{3'b000, exp_crc[12:8]}, exp_crc[7:0]};
    send_pkt(-1);
    n_tests++;
    if (rv_d !== 1'b1 || ok_d !== 1'b1 || sh_d !== 1'b0) begin
      n_fail++; $display("FAIL equiv_flags: got valid=%b ok=%b short=%b want 1 1 0", rv_d, ok_d, sh_d);
    end
    n_tests++;
    if (crc_d !== exp_crc || len_d !== 16'd6) begin
      n_fail++; $display("FAIL equiv_value: got crc=%h len=%0d want crc=%h len=6", crc_d, len_d, exp_crc);
    end
    consume();
  endtask

  task automatic test_short();
    send(8'h00, 1'b1, 1'b1);
    n_tests++;
    if ({rv_d, ok_d, sh_d} !== 3'b101 || crc_d !== INIT_D || len_d !== 16'd0) begin
      n_fail++; $display("FAIL short_default: got v/ok/sh=%b crc=%h len=%0d want 101 crc=%h len=0",
                         {rv_d, ok_d, sh_d}, crc_d, len_d, INIT_D);
    end
    // For CRC-8, one byte is a complete packet: an empty payload whose
    // trailer 00 matches init 0.
    n_tests++;
    if ({rv_8, ok_8, sh_8} !== 3'b110 || crc_8 !== 8'h00 || len_8 !== 16'd0) begin
      n_fail++; $display("FAIL short_crc8_single: got v/ok/sh=%b crc=%h len=%0d want 110 crc=00 len=0",
                         {rv_8, ok_8, sh_8}, crc_8, len_8);
    end
    consume();
  endtask

  task automatic test_empty();
    pay = '{};
    trl = '{8'h1F, 8'hFF};
    send_pkt(-1);
    n_tests++;
    if ({rv_d, ok_d, sh_d} !== 3'b110 || crc_d !== INIT_D || len_d !== 16'd0) begin
      n_fail++; $display("FAIL empty_payload: got v/ok/sh=%b crc=%h len=%0d want 110 crc=%h len=0",
                         {rv_d, ok_d, sh_d}, crc_d, len_d, INIT_D);
    end
    consume();
  endtask

  task automatic test_backpressure();
    load_check_pkt(8'hF4);
    send_pkt(-1);
    for (int c = 0; c < 5; c++) begin
      data = 8'h00; sop = 1'b1; eop = 1'b1; valid = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({rv_8, ready_8, ok_8} !== 3'b101 || crc_8 !== 8'hF4 || len_8 !== 16'd9) begin
        n_fail++; $display("FAIL backpressure_hold[%0d]: got v/rdy/ok=%b crc=%h len=%0d want 101 f4 9",
                           c, {rv_8, ready_8, ok_8}, crc_8, len_8);
      end
    end
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    consume();
    n_tests++;
    if ({rv_8, ready_8, rv_d, ready_d} !== 4'b0101) begin
      n_fail++; $display("FAIL backpressure_release: got %b want 0101", {rv_8, ready_8, rv_d, ready_d});
    end
    // The bytes offered while stalled must not have started a packet.
    idle_cycle();
    n_tests++;
    if (rv_8 !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_no_accept: got valid=%b want 0", rv_8);
    end
  endtask

  task automatic test_restart();
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    idle_cycle();
    send(8'hCC, 1'b0, 1'b0);
    load_check_pkt(8'hF4);
    send_pkt(3);
    n_tests++;
    if (res_before !== 1'b0) begin
      n_fail++; $display("FAIL restart_early_valid: got %b want 0", res_before);
    end
    n_tests++;
    if ({rv_8, ok_8} !== 2'b11 || crc_8 !== 8'hF4 || len_8 !== 16'd9) begin
      n_fail++; $display("FAIL restart_result: got v/ok=%b crc=%h len=%0d want 11 f4 9",
                         {rv_8, ok_8}, crc_8, len_8);
    end
    consume();
  endtask

  task automatic test_idle_drop();
    send(8'h31, 1'b0, 1'b0);
    send(8'hF4, 1'b0, 1'b1);
    n_tests++;
    if (rv_8 !== 1'b0 || rv_d !== 1'b0) begin
      n_fail++; $display("FAIL idle_drop: got valid_8=%b valid_d=%b want 0 0", rv_8, rv_d);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A trailing eop without sop now lands in IDLE and is dropped.
    send(8'hF4, 1'b0, 1'b1);
    n_tests++;
    if (rv_8 !== 1'b0 || ready_8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_discard: got valid=%b ready=%b want 0 1", rv_8, ready_8);
    end
    // A pending result is discarded by reset as well.
    load_check_pkt(8'hF4);
    send_pkt(-1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if ({rv_8, ok_8} !== 2'b00 || crc_8 !== 8'h00 || len_8 !== 16'd0) begin
      n_fail++; $display("FAIL reset_pending: got v/ok=%b crc=%h len=%0d want 00 00 0",
                         {rv_8, ok_8}, crc_8, len_8);
    end
    load_check_pkt(8'hF4);
    send_pkt(-1);
    n_tests++;
    if ({rv_8, ok_8} !== 2'b11 || crc_8 !== 8'hF4 || len_8 !== 16'd9) begin
      n_fail++; $display("FAIL reset_fresh_pkt: got v/ok=%b crc=%h len=%0d want 11 f4 9",
                         {rv_8, ok_8}, crc_8, len_8);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    pay = '{8'h41};
    trl = '{8'h00};
    send_pkt(-1);
    consume();
    // The next packet starts in the first cycle ready is high again.
    load_check_pkt(8'hF4);
    send_pkt(-1);
    n_tests++;
    if ({rv_8, ok_8} !== 2'b11 || crc_8 !== 8'hF4 || len_8 !== 16'd9) begin
      n_fail++; $display("FAIL back_to_back: got v/ok=%b crc=%h len=%0d want 11 f4 9",
                         {rv_8, ok_8}, crc_8, len_8);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_crc8_check();
    test_corrupt();
    test_equiv();
    test_short();
    test_empty();
    test_backpressure();
    test_restart();
    test_idle_drop();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
